// File: rtl/radix4_stride_reorder.sv
// ============================================================================
// Module   : radix4_stride_reorder
// Purpose  : Ping-pong reorder buffer that turns 4-wide radix-4 butterfly
//            groups into a natural-order serial bin stream (16-point FFT).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module radix4_stride_reorder #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] p1_re,
   input  logic [DW-1:0] p1_im,
   input  logic [DW-1:0] p2_re,
   input  logic [DW-1:0] p2_im,
   input  logic [DW-1:0] p3_re,
   input  logic [DW-1:0] p3_im,
   input  logic [DW-1:0] p4_re,
   input  logic [DW-1:0] p4_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic [3:0]    out_bin,
   output logic          out_last,
   output logic          overflow
);

   logic [2*DW-1:0] bank [2][16];
   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic            wbank;
   logic [1:0]      wbeat;
   logic            rbank;
   logic [3:0]      rbin;
   logic            wr_acc;
   logic            rd_acc;
   logic            wr_done;
   logic            rd_done;
   logic [2*DW-1:0] rd_word;

   assign in_ready  = !full[wbank];
   assign out_valid = full[rbank];
   assign wr_acc    = in_valid && in_ready;
   assign rd_acc    = out_valid && out_ready;
   assign wr_done   = wr_acc && (wbeat == 2'd3);
   assign rd_done   = rd_acc && (rbin == 4'd15);

   // Write side only sets, read side only clears; they never address the same bank.
   always_comb begin
      full_nxt = full;
      if (rd_done) full_nxt[rbank] = 1'b0;
      if (wr_done) full_nxt[wbank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 2'b00;
         wbank    <= 1'b0;
         wbeat    <= 2'd0;
         rbank    <= 1'b0;
         rbin     <= 4'd0;
         overflow <= 1'b0;
      end else begin
         full <= full_nxt;
         if (wr_acc) begin
            wbeat <= wbeat + 2'd1;
            if (wr_done) wbank <= ~wbank;
         end
         if (in_valid && !in_ready) overflow <= 1'b1;
         if (rd_acc) begin
            rbin <= rbin + 4'd1;
            if (rd_done) rbank <= ~rbank;
         end
      end
   end

   // Group n holds bins n, n+4, n+8, n+12: the stride is the upper two address bits.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         bank[wbank][{2'd0, wbeat}] <= {p1_re, p1_im};
         bank[wbank][{2'd1, wbeat}] <= {p2_re, p2_im};
         bank[wbank][{2'd2, wbeat}] <= {p3_re, p3_im};
         bank[wbank][{2'd3, wbeat}] <= {p4_re, p4_im};
      end
   end

   assign rd_word  = bank[rbank][rbin];
   assign out_re   = out_valid ? rd_word[2*DW-1:DW] : '0;
   assign out_im   = out_valid ? rd_word[DW-1:0]    : '0;
   assign out_bin  = rbin;
   assign out_last = out_valid && (rbin == 4'd15);

endmodule

`default_nettype wire

// File: tb/tb_radix4_stride_reorder.sv
// ============================================================================
// Module   : tb_radix4_stride_reorder
// Purpose  : Self-checking bench with a bin scoreboard for radix4_stride_reorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_radix4_stride_reorder;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] p1_re = '0, p1_im = '0, p2_re = '0, p2_im = '0;
   logic [DW-1:0] p3_re = '0, p3_im = '0, p4_re = '0, p4_im = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_re, out_im;
   logic [3:0]    out_bin;
   logic          out_last;
   logic          overflow;

   radix4_stride_reorder #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .p1_re(p1_re), .p1_im(p1_im), .p2_re(p2_re), .p2_im(p2_im),
      .p3_re(p3_re), .p3_im(p3_im), .p4_re(p4_re), .p4_im(p4_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_bin(out_bin),
      .out_last(out_last), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic [3:0]    bin;
      logic          last;
   } exp_t;

   typedef struct {
      int   grp;
      int   base;
      logic exp_ready;
      logic exp_ovf;
   } vec_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   run_len = 0;
   int   max_run = 0;

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_frame(input int base);
      exp_t e;
      for (int b = 0; b < 16; b++) begin
         e.re   = DW'(base + b);
         e.im   = DW'(-(base + b));
         e.bin  = 4'(b);
         e.last = (b == 15);
         sb.push_back(e);
      end
   endtask

   task automatic set_group(input int n, input int base);
      in_valid = 1'b1;
      p1_re = DW'(base + n);      p1_im = DW'(-(base + n));
      p2_re = DW'(base + n + 4);  p2_im = DW'(-(base + n + 4));
      p3_re = DW'(base + n + 8);  p3_im = DW'(-(base + n + 8));
      p4_re = DW'(base + n + 12); p4_im = DW'(-(base + n + 12));
   endtask

   task automatic send_frame(input int base);
      for (int n = 0; n < 4; n++) begin
         set_group(n, base);
         if (n == 3) push_frame(base);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((sb.size() != 0 || out_valid) && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, "_drain_timeout"}, (cyc < 300) ? 1 : 0, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_in_ready"},  int'(in_ready), 1);
      check({name, "_out_valid"}, int'(out_valid), 0);
      check({name, "_out_re"},    int'(out_re), 0);
      check({name, "_out_im"},    int'(out_im), 0);
      check({name, "_out_bin"},   int'(out_bin), 0);
      check({name, "_out_last"},  int'(out_last), 0);
      check({name, "_overflow"},  int'(overflow), 0);
   endtask

   // Scoreboard monitor: transfers, idle zeroing and hold stability.
   logic          held = 1'b0;
   logic [DW-1:0] held_re, held_im;
   logic [3:0]    held_bin;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
         run_len = 0;
      end else begin
         if (held) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_re", int'(out_re), int'(held_re));
            check("hold_im", int'(out_im), int'(held_im));
            check("hold_bin", int'(out_bin), int'(held_bin));
         end
         held = out_valid && !out_ready;
         held_re = out_re; held_im = out_im; held_bin = out_bin;
         if (!out_valid) begin
            run_len = 0;
            check("idle_re_zero", int'(out_re), 0);
            check("idle_last_zero", int'(out_last), 0);
         end else if (out_ready) begin
            exp_t e;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) begin
               check("unexpected_bin", int'(out_bin), -1);
            end else begin
               e = sb.pop_front();
               check("bin_re", int'(out_re), int'(e.re));
               check("bin_im", int'(out_im), int'(e.im));
               check("bin_idx", int'(out_bin), int'(e.bin));
               check("bin_last", int'(out_last), int'(e.last));
            end
         end
      end
   end

   initial begin
      vec_t tbl[12];
      int   cyc;
      for (int i = 0; i < 12; i++) begin
         tbl[i].grp       = i % 4;
         tbl[i].base      = 200 + 50 * (i / 4);
         tbl[i].exp_ready = (i < 8);
         tbl[i].exp_ovf   = (i >= 8);
      end

      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single frame
      out_ready = 1'b1;
      send_frame(0);
      check("single_valid_after_k", int'(out_valid), 1);
      check("single_bin0", int'(out_bin), 0);
      wait_drain("single");

      // Ping-pong back-to-back
      max_run = 0;
      send_frame(0);
      send_frame(100);
      wait_drain("pingpong");
      check("pingpong_run", max_run, 32);
      check("pingpong_overflow", int'(overflow), 0);

      // Backpressure 1,0,0,1 pattern
      out_ready = 1'b0;
      send_frame(300);
      cyc = 0;
      while ((sb.size() != 0 || out_valid) && cyc < 200) begin
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(posedge clk); #1;
         cyc++;
      end
      check("backpressure_timeout", (cyc < 200) ? 1 : 0, 1);

      // Overflow, table-driven
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         set_group(tbl[i].grp, tbl[i].base);
         check("ovf_in_ready", int'(in_ready), int'(tbl[i].exp_ready));
         if (tbl[i].exp_ready && tbl[i].grp == 3) push_frame(tbl[i].base);
         @(posedge clk); #1;
         check("ovf_flag", int'(overflow), int'(tbl[i].exp_ovf));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("overflow");
      check("ovf_sticky", int'(overflow), 1);

      // Reset mid-frame
      set_group(0, 400); @(posedge clk); #1;
      set_group(1, 400); @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_midframe");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(500);
      wait_drain("after_rst1");

      // Reset during bin 7 of a drain
      out_ready = 1'b1;
      send_frame(600);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(out_valid && out_bin == 4'd7) && cyc < 50);
      check("rst_drain_reach_bin7", int'(out_bin), 7);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_middrain");
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(700);
      wait_drain("after_rst2");

      // Simultaneous free/fill: bank1 completes on the edge bank0's bin 15 is taken
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_frame(800);
      repeat (12) begin @(posedge clk); #1; end
      send_frame(900);
      check("simul_valid", int'(out_valid), 1);
      check("simul_bin", int'(out_bin), 0);
      check("simul_re", int'(out_re), 900);
      check("simul_in_ready", int'(in_ready), 1);
      wait_drain("simul");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/radix4_stride_reorder.md
# radix4_stride_reorder

Output-side reorder buffer for the 16-point radix-4 FFT datapath. It consumes the four parallel outputs of the final radix-4 butterfly stage, one 4-sample group per beat. Group n carries bins n, n+4, n+8 and n+12. It emits the 16 bins serially in natural order (0..15) on a valid/ready stream. Two 16-entry banks in ping-pong let one frame drain while the next one fills.

## Interface
- DW, 16, width of each real/imag sample (two's complement, passed through unmodified)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  butterfly group present on p*_re/p*_im this cycle
- in_ready  out  1  write bank can accept a group this cycle
- p1_re, p1_im  in  DW each  bin n of group n
- p2_re, p2_im  in  DW each  bin n+4
- p3_re, p3_im  in  DW each  bin n+8
- p4_re, p4_im  in  DW each  bin n+12
- out_valid  out  1  out_re/out_im/out_bin hold a valid bin
- out_ready  in  1  downstream accepts the current bin
- out_re, out_im  out  DW each  bin data, forced to 0 while out_valid=0
- out_bin  out  4  bin index 0..15 of the current output
- out_last  out  1  high with bin 15 of a frame (qualified by out_valid)
- overflow  out  1  sticky: a group arrived while in_ready=0 and was dropped

## Operation
- Storage: bank[0..1], each 16 entries × 2·DW. Each bank has a full flag.
- Write side: wbank (1 bit), wbeat (2 bits). in_ready = !full[wbank].
- Group acceptance: accepted when in_valid && in_ready. The four samples are written to bank[wbank] entries wbeat, wbeat+4, wbeat+8, wbeat+12 (p1..p4 respectively). wbeat then increments.
- Frame completion on the write side: accepting with wbeat==3 sets full[wbank], toggles wbank, and wraps wbeat to 0.
- Dropped groups: in_valid && !in_ready discards the group, sets overflow, and leaves wbeat unchanged. The upstream butterfly cannot stall; the bench and system must guarantee ≤1 frame per 16 output cycles.
- Read side: rbank (1 bit), rbin (4 bits). out_valid = full[rbank]. out_re/out_im = bank[rbank][rbin]. out_bin = rbin. out_last = out_valid && rbin==15.
- Output transfer: each out_valid && out_ready advances rbin. A transfer at rbin==15 clears full[rbank], toggles rbank, and wraps rbin to 0.
- Holding: out_valid=1 with out_ready=0 holds all outputs stable. Data must not change while valid and not accepted.
- Simultaneous events: a write that completes a frame in bank A and a read that frees bank B in the same cycle both take effect. Flags are updated per-bank, independently.
- Flag ownership: the write side only sets flags and the read side only clears them. Both banks can never target the same flag in one cycle, because wbank≠rbank whenever both banks are busy.
- Reset (any time, including mid-frame or mid-drain): both full flags cleared; wbank=rbank=0; wbeat=0; rbin=0; overflow=0. Partially written frames are discarded. Bank contents are don't-care and need no reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=out_im=0, out_bin=0, out_last=0, overflow=0.
- Write latency: the 4th group is accepted at edge k, and out_valid=1 with bin 0 from edge k onward (visible in the cycle after k).
- Drain rate: with out_ready held high, bins 0..15 appear on 16 consecutive cycles. The next full bank follows with no bubble.
- Freeing a bank: when bin 15 is taken at edge j, in_ready for that bank is high after edge j. There is no combinational path from out_ready to in_ready.
- Sustained throughput: 1 bin/cycle out and 1 frame per 16 cycles in. Input bursts of up to 2 frames are absorbed while the output is stalled.
- overflow asserts the cycle after the dropped group's edge.

## Test plan
- Single frame: after reset, drive groups n=0..3 with p1_re=n, p2_re=n+4, p3_re=n+8, p4_re=n+12 (im = −re) on 4 consecutive cycles, out_ready=1 → out_re=0,1,…,15 on 16 consecutive cycles, out_im=−out_re, out_bin matches, out_last only on bin 15.
- Ping-pong back-to-back: two frames (8 groups, data offset +100 on frame 2) with out_ready=1 → 32 consecutive valid bins, frame 2 starting right after bin 15 of frame 1 with no gap, overflow=0.
- Backpressure: out_ready toggled 1,0,0,1,… during drain → every bin appears exactly once in order, and out_re/out_bin are stable while out_valid && !out_ready.
- Overflow: out_ready=0, push 3 frames → in_ready drops after 8 groups, overflow=1 from the 9th group on, and the first two frames then drain intact (bins 0..15 twice).
- Reset mid-operation: assert rst_n=0 after 2 groups of frame 1 and again during bin 7 of a drain → all outputs at reset values immediately (async). A fresh frame after release drains correctly from bin 0.
- Simultaneous free/fill: bank 0 draining, and the last group of bank 1 arrives in the same cycle bin 15 of bank 0 is taken → bank 1 bin 0 is valid the next cycle, and in_ready=1 for bank 0.
